// File: rtl/dmem_requester_if.sv
// Core-side request/response channel of the data memory requester.
//   master : the core; drives req_* and observes ready_o / resp_*
//   slave  : dmem_requester; accepts req_* and returns ready_o / resp_*
interface dmem_requester_if #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 16
);
  logic               req_valid_i;
  logic               req_we_i;
  logic [A_WIDTH-1:0] req_addr_i;
  logic [D_WIDTH-1:0] req_data_i;
  logic               ready_o;
  logic               resp_valid_o;
  logic [D_WIDTH-1:0] resp_data_o;
  logic               resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_data_i,
    input  ready_o, resp_valid_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_data_i,
    output ready_o, resp_valid_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/dmem_requester.sv
// Data memory requester: takes one core access at a time, issues it to a
// memory that may refuse it, retries refused accesses up to MAX_RETRY
// attempts and returns a single-cycle response (data or retry error).
// Ports:
//   clk, reset_n_i      : clock, asynchronous active-low reset
//   core (slave)        : req_valid/we/addr/data in, ready/resp_valid/data/err out
//   read_write_req_o    : memory request strobe (one cycle per attempt)
//   write_en_o          : memory write enable, qualified by the strobe
//   addr_o, din_o       : memory address / write data (latched request)
//   dout_i, refused_i   : memory read data / refusal, valid the cycle after the strobe
//   refuse_cnt_o        : saturating count of refusals seen
// MAX_RETRY must lie in 1..7.
module dmem_requester #(
  parameter int unsigned A_WIDTH   = 10,
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic               clk,
  input  logic               reset_n_i,
  dmem_requester_if.slave    core,
  output logic               read_write_req_o,
  output logic               write_en_o,
  output logic [A_WIDTH-1:0] addr_o,
  output logic [D_WIDTH-1:0] din_o,
  input  logic [D_WIDTH-1:0] dout_i,
  input  logic               refused_i,
  output logic [15:0]        refuse_cnt_o
);

  localparam int unsigned RETRY_W = 3;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state;
  logic               lat_we;
  logic [RETRY_W-1:0] retry_cnt;
  logic               ready;
  logic               resp_valid;
  logic [D_WIDTH-1:0] resp_data;
  logic               resp_err;
  logic               rw_req;
  logic               wr_en;
  logic [A_WIDTH-1:0] addr;
  logic [D_WIDTH-1:0] din;
  logic [CNT_W-1:0]   refuse_cnt;

  // Retry budget is spent when this refusal is the MAX_RETRY-th one.
  logic               retry_exhausted;
  assign retry_exhausted = (retry_cnt + RETRY_W'(1)) >= RETRY_W'(MAX_RETRY);

  // FSM with every output registered from the next-state decision, so the
  // memory side never sees a combinational path from req_* inputs.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      retry_cnt  <= '0;
      ready      <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      rw_req     <= 1'b0;
      wr_en      <= 1'b0;
      addr       <= '0;
      din        <= '0;
      refuse_cnt <= '0;
    end else begin
      // Response fields live for exactly one cycle.
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (core.req_valid_i) begin
            lat_we    <= core.req_we_i;
            addr      <= core.req_addr_i;
            din       <= core.req_data_i;
            retry_cnt <= '0;
            rw_req    <= 1'b1;
            wr_en     <= core.req_we_i;
            ready     <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          rw_req <= 1'b0;
          wr_en  <= 1'b0;
          state  <= CHECK;
        end
        CHECK: begin
          if (!refused_i) begin
            resp_valid <= 1'b1;
            resp_data  <= lat_we ? '0 : dout_i;
            ready      <= 1'b1;
            state      <= IDLE;
          end else begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            if (refuse_cnt != {CNT_W{1'b1}}) begin
              refuse_cnt <= refuse_cnt + CNT_W'(1);
            end
            if (retry_exhausted) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              ready      <= 1'b1;
              state      <= IDLE;
            end else begin
              // Refused writes were not performed: re-issue the same fields.
              rw_req <= 1'b1;
              wr_en  <= lat_we;
              state  <= ISSUE;
            end
          end
        end
        default: begin
          rw_req <= 1'b0;
          wr_en  <= 1'b0;
          ready  <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign core.ready_o      = ready;
  assign core.resp_valid_o = resp_valid;
  assign core.resp_data_o  = resp_data;
  assign core.resp_err_o   = resp_err;
  assign read_write_req_o  = rw_req;
  assign write_en_o        = wr_en;
  assign addr_o            = addr;
  assign din_o             = din;
  assign refuse_cnt_o      = refuse_cnt;

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: a refusing memory model, a table of single
// accesses, back-to-back reads and resets in ISSUE and CHECK.
module tb_dmem_requester;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        read_write_req_o;
  logic        write_en_o;
  logic [9:0]  addr_o;
  logic [15:0] din_o;
  logic [15:0] dout_i;
  logic        refused_i;
  logic [15:0] refuse_cnt_o;

  dmem_requester_if #(.A_WIDTH(10), .D_WIDTH(16)) cif ();

  dmem_requester #(.A_WIDTH(10), .D_WIDTH(16), .MAX_RETRY(4)) dut (
    .clk              (clk),
    .reset_n_i        (reset_n_i),
    .core             (cif),
    .read_write_req_o (read_write_req_o),
    .write_en_o       (write_en_o),
    .addr_o           (addr_o),
    .din_o            (din_o),
    .dout_i           (dout_i),
    .refused_i        (refused_i),
    .refuse_cnt_o     (refuse_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [15:0] data;
    int          refusals;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_issues;
    int          exp_rcnt;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          issues = 0;
  int          issues_start = 0;
  int          cur_ref = 0;
  logic        cur_we = 1'b0;
  logic [9:0]  cur_addr = '0;
  logic [15:0] cur_data = '0;
  logic [15:0] mem [1024];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: answers one cycle after a strobe; refuses the first cur_ref
  // attempts of the current access; drives junk when not answering.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[5] = 16'hBEEF;
  end

  always @(posedge clk) begin
    if (read_write_req_o) begin
      if ((issues - issues_start) <= cur_ref) begin
        refused_i <= 1'b1;
      end else begin
        refused_i <= 1'b0;
        if (write_en_o) mem[addr_o] <= din_o;
      end
      dout_i <= write_en_o ? 16'($urandom) : mem[addr_o];
    end else begin
      refused_i <= 1'($urandom);
      dout_i    <= 16'($urandom);
    end
  end

  // Monitor: strobe field checks and scoreboard comparison of responses.
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (read_write_req_o) begin
        issues++;
        check("strobe_we", 32'(write_en_o), 32'(cur_we));
        check("strobe_addr", 32'(addr_o), 32'(cur_addr));
        check("strobe_din", 32'(din_o), 32'(cur_data));
        check("strobe_ready_low", 32'(cif.ready_o), 32'd0);
      end
      if (cif.resp_valid_o) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_data", 32'(cif.resp_data_o), 32'(e.data));
          check("resp_err", 32'(cif.resp_err_o), 32'(e.err));
          check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    for (int k = 0; k < 50 && cif.ready_o !== 1'b1; k++) @(negedge clk);
    if (cif.ready_o !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0b required=1", nm, cif.ready_o);
    end
  endtask

  task automatic wait_empty(input string nm);
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_no_resp actual=%0d required=0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  // Starts a refused read, then resets in ISSUE (phase 1) or CHECK (phase 2).
  task automatic mid_reset(input int phase);
    wait_ready("rst_ready");
    cur_we = 1'b0; cur_addr = 10'h005; cur_data = 16'h0; cur_ref = 1;
    issues_start = issues;
    cif.req_we_i = 1'b0; cif.req_addr_i = 10'h005; cif.req_data_i = 16'h0;
    cif.req_valid_i = 1'b1;
    @(negedge clk);
    cif.req_valid_i = 1'b0;
    if (phase == 2) @(negedge clk);
    #1 reset_n_i = 1'b0;
    #1;
    check("rst_rw_req", 32'(read_write_req_o), 32'd0);
    check("rst_ready", 32'(cif.ready_o), 32'd1);
    check("rst_refuse_cnt", 32'(refuse_cnt_o), 32'd0);
    check("rst_resp_valid", 32'(cif.resp_valid_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_rw_req", 32'(read_write_req_o), 32'd0);
    check("post_rst_ready", 32'(cif.ready_o), 32'd1);
  endtask

  initial begin
    vec_t        vt[9];
    logic [9:0]  b_addr[3];
    logic [15:0] b_data[3];
    int          acc_prev;

    //          we    addr     data      ref exp_data  err lat iss rcnt
    vt[0] = '{1'b0, 10'h005, 16'h0000, 0, 16'hBEEF, 1'b0, 3, 1, 0};
    vt[1] = '{1'b1, 10'h3FF, 16'h1234, 0, 16'h0000, 1'b0, 3, 1, 0};
    vt[2] = '{1'b0, 10'h3FF, 16'h0000, 0, 16'h1234, 1'b0, 3, 1, 0};
    vt[3] = '{1'b0, 10'h005, 16'h0000, 1, 16'hBEEF, 1'b0, 5, 2, 1};
    vt[4] = '{1'b1, 10'h010, 16'h5555, 4, 16'h0000, 1'b1, 9, 4, 5};
    vt[5] = '{1'b0, 10'h010, 16'h0000, 0, 16'h0000, 1'b0, 3, 1, 5};
    vt[6] = '{1'b1, 10'h010, 16'hA5A5, 2, 16'h0000, 1'b0, 7, 3, 7};
    vt[7] = '{1'b0, 10'h010, 16'h0000, 3, 16'hA5A5, 1'b0, 9, 4, 10};
    vt[8] = '{1'b0, 10'h000, 16'h0000, 0, 16'h0000, 1'b0, 3, 1, 10};

    cif.req_valid_i = 1'b0;
    cif.req_we_i    = 1'b0;
    cif.req_addr_i  = '0;
    cif.req_data_i  = '0;

    #1 reset_n_i = 1'b0;
    #2;
    check("reset_ready", 32'(cif.ready_o), 32'd1);
    check("reset_rw_req", 32'(read_write_req_o), 32'd0);
    check("reset_we_addr_din", {5'(0), write_en_o, addr_o, din_o}, 32'd0);
    check("reset_resp", {14'(0), cif.resp_valid_o, cif.resp_err_o, cif.resp_data_o}, 32'd0);
    check("reset_refuse_cnt", 32'(refuse_cnt_o), 32'd0);
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;

    // Table of single accesses with injected refusals.
    for (int i = 0; i < 9; i++) begin
      wait_ready("row_ready");
      cur_we = vt[i].we; cur_addr = vt[i].addr; cur_data = vt[i].data;
      cur_ref = vt[i].refusals;
      issues_start = issues;
      cif.req_we_i = vt[i].we; cif.req_addr_i = vt[i].addr; cif.req_data_i = vt[i].data;
      cif.req_valid_i = 1'b1;
      sbq.push_back('{vt[i].exp_data, vt[i].exp_err, vt[i].exp_lat, cyc});
      @(negedge clk);
      // Junk on req_* while busy must not leak into the access.
      cif.req_valid_i = 1'b0;
      cif.req_we_i    = 1'($urandom);
      cif.req_addr_i  = 10'($urandom);
      cif.req_data_i  = 16'($urandom);
      wait_empty("row");
      check("row_issues", 32'(issues - issues_start), 32'(vt[i].exp_issues));
      check("row_refuse_cnt", 32'(refuse_cnt_o), 32'(vt[i].exp_rcnt));
    end

    // Back-to-back reads with req_valid_i held high.
    b_addr[0] = 10'h005; b_data[0] = 16'hBEEF;
    b_addr[1] = 10'h3FF; b_data[1] = 16'h1234;
    b_addr[2] = 10'h010; b_data[2] = 16'hA5A5;
    wait_ready("b2b_ready");
    cur_ref = 0;
    acc_prev = cyc - 3;
    cif.req_valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cur_we = 1'b0; cur_addr = b_addr[n]; cur_data = 16'h0;
      cif.req_we_i = 1'b0; cif.req_addr_i = b_addr[n]; cif.req_data_i = 16'h0;
      check("b2b_ready", 32'(cif.ready_o), 32'd1);
      if (n > 0) check("b2b_spacing", 32'(cyc - acc_prev), 32'd3);
      acc_prev = cyc;
      sbq.push_back('{b_data[n], 1'b0, 3, cyc});
      repeat (3) @(negedge clk);
    end
    cif.req_valid_i = 1'b0;
    wait_empty("b2b");

    mid_reset(1);
    mid_reset(2);
    check("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
